// File: rtl/arbiter_round_robin.sv
`default_nettype none
// ============================================================================
// Module   : arbiter_round_robin (with helper priority_encoder_base)
// Brief    : Round-robin arbiter, registered one-hot grant, hold-until-release,
//            optional time-quantum preemption.
// Revision : 1.0
// ============================================================================

module priority_encoder_base #(
    parameter int WIDTH          = 4,
    parameter int IMPLEMENTATION = 0
) (
    input  logic [WIDTH-1:0]         in_vec,
    output logic [$clog2(WIDTH)-1:0] idx,
    output logic                     vld
);
    localparam int IDX_W = $clog2(WIDTH);

    assign vld = |in_vec;

    generate
        if (IMPLEMENTATION != 0 && WIDTH == 2) begin : g_tree2
            assign idx = ~in_vec[0] & in_vec[1];
        end else if (IMPLEMENTATION != 0 && WIDTH == 4) begin : g_tree4
            always_comb begin
                casez (in_vec)
                    4'b???1: idx = 2'd0;
                    4'b??10: idx = 2'd1;
                    4'b?100: idx = 2'd2;
                    4'b1000: idx = 2'd3;
                    default: idx = 2'd0;
                endcase
            end
        end else begin : g_linear
            // Scan downward so the lowest set bit is the last one written.
            always_comb begin
                idx = '0;
                for (int i = WIDTH - 1; i >= 0; i--) begin
                    if (in_vec[i]) idx = i[IDX_W-1:0];
                end
            end
        end
    endgenerate
endmodule

module arbiter_round_robin #(
    parameter int WIDTH          = 4,
    parameter int QUANTUM        = 0,
    parameter int IMPLEMENTATION = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WIDTH-1:0]         req,
    output logic [WIDTH-1:0]         gnt,
    output logic [$clog2(WIDTH)-1:0] gnt_idx,
    output logic                     gnt_vld
);
    localparam int WIDTH_LOG = $clog2(WIDTH);
    localparam int CNT_W     = (QUANTUM == 0) ? 1 : $clog2(QUANTUM + 1);

    localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]     CNT_MAX  = CNT_W'(QUANTUM);
    localparam logic [WIDTH_LOG-1:0] IDX_LAST = WIDTH_LOG'(WIDTH - 1);
    localparam logic [WIDTH_LOG-1:0] IDX_ONE  = WIDTH_LOG'(1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t               state_q,   state_d;
    logic [WIDTH_LOG-1:0] ptr_q,     ptr_d;
    logic [CNT_W-1:0]     cnt_q,     cnt_d;
    logic [WIDTH-1:0]     gnt_q,     gnt_d;
    logic [WIDTH_LOG-1:0] gnt_idx_q, gnt_idx_d;
    logic                 gnt_vld_q, gnt_vld_d;

    logic [WIDTH_LOG-1:0] g_next;
    logic                 release_grant;
    logic                 preempt_grant;
    logic [WIDTH-1:0]     pick_vec;
    logic [WIDTH_LOG-1:0] pick_start;
    logic [WIDTH-1:0]     start_mask;
    logic [WIDTH-1:0]     masked_vec;
    logic [WIDTH_LOG-1:0] masked_idx, full_idx, pick_idx;
    logic                 masked_vld, full_vld;
    logic [WIDTH-1:0]     pick_onehot;

    assign g_next = (gnt_idx_q == IDX_LAST) ? '0 : gnt_idx_q + IDX_ONE;

    assign release_grant = (state_q == BUSY) && !req[gnt_idx_q];
    assign preempt_grant = (state_q == BUSY) && req[gnt_idx_q] && (QUANTUM != 0)
                        && (cnt_q == CNT_MAX) && (|(req & ~gnt_q));

    // The current owner is excluded from the search; on release its request is
    // already low and in IDLE gnt_q is zero, so one expression covers every case.
    assign pick_vec   = req & ~gnt_q;
    assign pick_start = (state_q == BUSY) ? g_next : ptr_q;

    always_comb begin
        start_mask = '0;
        for (int i = 0; i < WIDTH; i++) begin
            start_mask[i] = (i >= int'(pick_start));
        end
    end

    assign masked_vec = pick_vec & start_mask;

    priority_encoder_base #(
        .WIDTH          (WIDTH),
        .IMPLEMENTATION (IMPLEMENTATION)
    ) u_pe_masked (
        .in_vec (masked_vec),
        .idx    (masked_idx),
        .vld    (masked_vld)
    );

    priority_encoder_base #(
        .WIDTH          (WIDTH),
        .IMPLEMENTATION (IMPLEMENTATION)
    ) u_pe_full (
        .in_vec (pick_vec),
        .idx    (full_idx),
        .vld    (full_vld)
    );

    assign pick_idx = masked_vld ? masked_idx : full_idx;

    always_comb begin
        pick_onehot           = '0;
        pick_onehot[pick_idx] = 1'b1;
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        gnt_d     = gnt_q;
        gnt_idx_d = gnt_idx_q;
        gnt_vld_d = gnt_vld_q;

        case (state_q)
            IDLE: begin
                if (full_vld) begin
                    state_d   = BUSY;
                    gnt_d     = pick_onehot;
                    gnt_idx_d = pick_idx;
                    gnt_vld_d = 1'b1;
                    cnt_d     = CNT_ONE;
                end
            end
            BUSY: begin
                if (release_grant) begin
                    ptr_d = g_next;
                    if (full_vld) begin
                        gnt_d     = pick_onehot;
                        gnt_idx_d = pick_idx;
                        gnt_vld_d = 1'b1;
                        cnt_d     = CNT_ONE;
                    end else begin
                        state_d   = IDLE;
                        gnt_d     = '0;
                        gnt_idx_d = '0;
                        gnt_vld_d = 1'b0;
                    end
                end else if (preempt_grant) begin
                    ptr_d     = g_next;
                    gnt_d     = pick_onehot;
                    gnt_idx_d = pick_idx;
                    cnt_d     = CNT_ONE;
                end else if (QUANTUM == 0) begin
                    cnt_d = CNT_ONE;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d   = IDLE;
                gnt_d     = '0;
                gnt_idx_d = '0;
                gnt_vld_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            cnt_q     <= '0;
            gnt_q     <= '0;
            gnt_idx_q <= '0;
            gnt_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            gnt_q     <= gnt_d;
            gnt_idx_q <= gnt_idx_d;
            gnt_vld_q <= gnt_vld_d;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_idx = gnt_idx_q;
    assign gnt_vld = gnt_vld_q;
endmodule

`default_nettype wire

// File: tb/tb_arbiter_round_robin.sv
`default_nettype none
// ============================================================================
// Module   : tb_arbiter_round_robin
// Brief    : Two arbiters (QUANTUM=4 and QUANTUM=0) on a shared request bus,
//            compared against a rotating-search reference model.
// Revision : 1.0
// ============================================================================
module tb_arbiter_round_robin;
    localparam int W = 4;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] req   = '0;
    logic [W-1:0] gnt_a, gnt_b;
    logic [1:0]   idx_a, idx_b;
    logic         vld_a, vld_b;

    int n_checks = 0;
    int n_fail   = 0;

    int m_own [2];
    int m_ptr [2];
    int m_cnt [2];
    int m_q   [2] = '{4, 0};

    always #5 clk = ~clk;

    arbiter_round_robin #(.WIDTH(4), .QUANTUM(4), .IMPLEMENTATION(0)) dut_q4 (
        .clk(clk), .rst_n(rst_n), .req(req),
        .gnt(gnt_a), .gnt_idx(idx_a), .gnt_vld(vld_a)
    );

    arbiter_round_robin #(.WIDTH(4), .QUANTUM(0), .IMPLEMENTATION(1)) dut_q0 (
        .clk(clk), .rst_n(rst_n), .req(req),
        .gnt(gnt_b), .gnt_idx(idx_b), .gnt_vld(vld_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // First requester found when searching upward from s, wrapping around.
    function automatic int pick(input logic [W-1:0] r, input int s);
        for (int k = 0; k < W; k++) begin
            if (r[(s + k) % W]) return (s + k) % W;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_own[m] = -1;
            m_ptr[m] = 0;
            m_cnt[m] = 0;
        end
    endtask

    task automatic model_step(input logic [W-1:0] r);
        logic [W-1:0] own_bit;
        for (int m = 0; m < 2; m++) begin
            if (m_own[m] < 0) begin
                if (r != 0) begin
                    m_own[m] = pick(r, m_ptr[m]);
                    m_cnt[m] = 1;
                end
            end else begin
                own_bit = 4'b0001 << m_own[m];
                if ((r & own_bit) == 0) begin
                    m_ptr[m] = (m_own[m] + 1) % W;
                    m_own[m] = (r != 0) ? pick(r, m_ptr[m]) : -1;
                    m_cnt[m] = 1;
                end else if (m_q[m] != 0 && m_cnt[m] == m_q[m] && (r & ~own_bit) != 0) begin
                    m_ptr[m] = (m_own[m] + 1) % W;
                    m_own[m] = pick(r & ~own_bit, m_ptr[m]);
                    m_cnt[m] = 1;
                end else if (m_q[m] == 0) begin
                    m_cnt[m] = 1;
                end else if (m_cnt[m] < m_q[m]) begin
                    m_cnt[m] = m_cnt[m] + 1;
                end
            end
        end
    endtask

    function automatic logic [W-1:0] exp_gnt(input int m);
        return (m_own[m] < 0) ? 4'b0000 : (4'b0001 << m_own[m]);
    endfunction

    task automatic check_model();
        check_eq("q4_gnt", gnt_a, exp_gnt(0));
        check_eq("q4_vld", vld_a, m_own[0] >= 0);
        check_eq("q4_idx", idx_a, (m_own[0] < 0) ? 0 : m_own[0]);
        check_eq("q0_gnt", gnt_b, exp_gnt(1));
        check_eq("q0_vld", vld_b, m_own[1] >= 0);
        check_eq("q0_idx", idx_b, (m_own[1] < 0) ? 0 : m_own[1]);
    endtask

    task automatic cycle(input logic [W-1:0] r);
        req = r;
        @(posedge clk);
        model_step(r);
        @(negedge clk);
        check_model();
    endtask

    // Reset is asserted between edges; grants must drop before any clock edge.
    task automatic hard_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("async_clr_q4", gnt_a, 0);
        check_eq("async_clr_q0", gnt_b, 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        logic [W-1:0] drop;
        logic [W-1:0] rq;
        model_reset();

        req   = 4'b1111;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_gnt", gnt_a, 0);
        check_eq("rst_vld", vld_a, 0);
        check_eq("rst_idx", idx_a, 0);
        check_eq("rst_gnt_q0", gnt_b, 0);
        rst_n = 1'b1;
        cycle(4'b1111);
        check_eq("rst_first_gnt", gnt_a, 4'b0001);

        for (int k = 0; k < 5; k++) begin
            check_eq("fair_order", gnt_a, 4'b0001 << (k % 4));
            check_eq("fair_no_bubble", vld_a, 1);
            cycle(4'b1111);
            drop = 4'b1111 & ~(4'b0001 << (k % 4));
            cycle(drop);
        end

        hard_reset();
        for (int k = 0; k < 16; k++) begin
            cycle(4'b0101);
            check_eq("quantum_q4", gnt_a, (((k / 4) % 2) == 0) ? 4'b0001 : 4'b0100);
            check_eq("quantum_q0", gnt_b, 4'b0001);
        end

        hard_reset();
        for (int k = 0; k < 20; k++) begin
            cycle(4'b0010);
            check_eq("lone_q4", gnt_a, 4'b0010);
        end

        hard_reset();
        cycle(4'b1000);
        cycle(4'b1101);
        cycle(4'b1101);
        check_eq("wrap_hold3", gnt_a, 4'b1000);
        cycle(4'b0101);
        check_eq("wrap_to0", gnt_a, 4'b0001);
        cycle(4'b0100);
        check_eq("wrap_then2", gnt_a, 4'b0100);
        cycle(4'b0000);
        check_eq("idle_return", gnt_a, 4'b0000);
        check_eq("idle_vld", vld_a, 0);

        cycle(4'b1010);
        check_eq("pre_rst_from_ptr3", gnt_a, 4'b1000);
        hard_reset();
        cycle(4'b1010);
        check_eq("post_rst_from_ptr0", gnt_a, 4'b0010);

        rq = 4'b0000;
        for (int n = 0; n < 400; n++) begin
            if (n == 200) hard_reset();
            for (int i = 0; i < W; i++) begin
                if (rq[i] && m_own[0] == i) begin
                    if ($urandom_range(3) == 0) rq[i] = 1'b0;
                end else if (rq[i]) begin
                    if ($urandom_range(11) == 0) rq[i] = 1'b0;
                end else begin
                    if ($urandom_range(2) == 0) rq[i] = 1'b1;
                end
            end
            cycle(rq);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
